// File: rtl/denise_clut_pkg.sv
// Shared configuration for the Denise colour lookup table RAM.
package denise_clut_pkg;

  localparam int unsigned CLUT_ADDR_W = 8;
  localparam int unsigned CLUT_DATA_W = 32;
  localparam int unsigned CLUT_LANES  = CLUT_DATA_W / 8;

  typedef logic [CLUT_LANES-1:0] byteena_t;

endpackage : denise_clut_pkg

// File: rtl/denise_clut_bytelane.sv
// One 8-bit byte lane of the colour table: synchronous write, combinational read.
// The read is left unregistered so the top level can merge bypass data before q.
module denise_clut_bytelane #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wraddress] <= wdata;
    end
  end

  always_comb begin
    rdata = mem[rdaddress];
  end

endmodule : denise_clut_bytelane

// File: rtl/denise_colortable_ram_mf.sv
// Simple dual-port byte-enabled colour table RAM with a registered read port.
// Define DENISE_CLUT_RDW_BYPASS_EN to return new data on same-address read-during-write.
module denise_colortable_ram_mf
  import denise_clut_pkg::*;
#(
  parameter int unsigned ADDR_W = CLUT_ADDR_W,
  parameter int unsigned DATA_W = CLUT_DATA_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   wraddress,
  input  logic                wren,
  input  logic [DATA_W/8-1:0] byteena_a,
  input  logic [DATA_W-1:0]   data,
  input  logic [ADDR_W-1:0]   rdaddress,
  output logic [DATA_W-1:0]   q
);

  localparam int unsigned LANES = DATA_W / 8;

  logic [LANES-1:0]  lane_we;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_merged;

  // reset_n gates the lane enables so an asserted reset blocks writes outright
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_we[i] = enable & wren & byteena_a[i] & reset_n;

    denise_clut_bytelane #(
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clock     (clock),
      .we        (lane_we[i]),
      .wraddress (wraddress),
      .wdata     (data[8*i +: 8]),
      .rdaddress (rdaddress),
      .rdata     (rd_word[8*i +: 8])
    );
  end

  always_comb begin
    rd_merged = rd_word;
`ifdef DENISE_CLUT_RDW_BYPASS_EN
    if (wren && (wraddress == rdaddress)) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (byteena_a[i]) begin
          rd_merged[8*i +: 8] = data[8*i +: 8];
        end
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (enable) begin
      q <= rd_merged;
    end
  end

endmodule : denise_colortable_ram_mf

// File: tb/tb_denise_colortable_ram_mf.sv
// Self-checking bench for denise_colortable_ram_mf: directed table, reset sequence, random phase.
module tb_denise_colortable_ram_mf;
  import denise_clut_pkg::*;

`ifdef DENISE_CLUT_RDW_BYPASS_EN
  localparam bit RDW_NEW = 1'b1;
`else
  localparam bit RDW_NEW = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  wraddress = '0;
  logic        wren = 1'b0;
  byteena_t    byteena_a = '0;
  logic [31:0] data = '0;
  logic [7:0]  rdaddress = '0;
  logic [31:0] q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [256];
  logic [31:0] model_q = '0;

  denise_colortable_ram_mf #(
    .ADDR_W (8),
    .DATA_W (32)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .wraddress (wraddress),
    .wren      (wren),
    .byteena_a (byteena_a),
    .data      (data),
    .rdaddress (rdaddress),
    .q         (q)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          en;
    bit          we;
    logic [7:0]  wa;
    logic [3:0]  be;
    logic [31:0] d;
    logic [7:0]  ra;
    bit          chk;
    logic [31:0] exp_q;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: q=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Called at a negedge: drives one cycle, updates the reference at posedge, returns at the next negedge.
  task automatic step(input bit en, input bit we, input logic [7:0] wa, input logic [3:0] be,
                      input logic [31:0] d, input logic [7:0] ra, output logic [31:0] exp);
    enable = en; wren = we; wraddress = wa; byteena_a = be; data = d; rdaddress = ra;
    @(posedge clock);
    if (reset_n && en) begin
      if (RDW_NEW && we && (wa == ra)) model_q = merge_lanes(model_mem[ra], d, be);
      else                             model_q = model_mem[ra];
      if (we) model_mem[wa] = merge_lanes(model_mem[wa], d, be);
    end
    exp = model_q;
    @(negedge clock);
  endtask

  vec_t        vecs[$];
  logic [31:0] exp;

  initial begin
    // Reset state
    #3;
    check("reset_q", q, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Preload every word so the reference model knows all contents
    for (int a = 0; a < 256; a++) step(1, 1, 8'(a), 4'hF, $urandom, 8'h00, exp);
    step(1, 0, 8'h00, 4'h0, 32'h0, 8'h01, exp);
    check("preload_read", q, exp);

    // Directed table
    vecs.push_back('{1, 1, 8'h05, 4'hF, 32'h0ABC0DEF, 8'h06, 0, 32'h0});
    vecs.push_back('{1, 0, 8'h00, 4'h0, 32'h0,        8'h05, 1, 32'h0ABC0DEF});
    vecs.push_back('{1, 1, 8'h05, 4'h3, 32'h01230456, 8'h06, 0, 32'h0});
    vecs.push_back('{1, 0, 8'h00, 4'h0, 32'h0,        8'h05, 1, 32'h0ABC0456});
    vecs.push_back('{1, 1, 8'h10, 4'hF, 32'h12345678, 8'h06, 0, 32'h0});
    vecs.push_back('{1, 0, 8'h00, 4'h0, 32'h0,        8'h10, 1, 32'h12345678});
    vecs.push_back('{0, 1, 8'h10, 4'hF, 32'hFFFFFFFF, 8'h10, 1, 32'h12345678});
    vecs.push_back('{0, 1, 8'h10, 4'hF, 32'hFFFFFFFF, 8'h05, 1, 32'h12345678});
    vecs.push_back('{1, 0, 8'h00, 4'h0, 32'h0,        8'h10, 1, 32'h12345678});
    vecs.push_back('{1, 1, 8'h20, 4'hF, 32'h11111111, 8'h10, 1, 32'h12345678});
    vecs.push_back('{1, 1, 8'h20, 4'hF, 32'h22222222, 8'h20, 1, RDW_NEW ? 32'h22222222 : 32'h11111111});
    vecs.push_back('{1, 0, 8'h00, 4'h0, 32'h0,        8'h20, 1, 32'h22222222});
    vecs.push_back('{1, 1, 8'h20, 4'h5, 32'h33333333, 8'h20, 1, RDW_NEW ? 32'h22332233 : 32'h22222222});
    vecs.push_back('{1, 0, 8'h00, 4'h0, 32'h0,        8'h20, 1, 32'h22332233});
    vecs.push_back('{1, 1, 8'hFF, 4'hF, 32'hA5A5A5A5, 8'h20, 1, 32'h22332233});
    vecs.push_back('{1, 1, 8'h00, 4'hF, 32'h5A5A5A5A, 8'hFF, 1, 32'hA5A5A5A5});
    vecs.push_back('{1, 0, 8'h00, 4'h0, 32'h0,        8'h00, 1, 32'h5A5A5A5A});
    vecs.push_back('{1, 0, 8'h00, 4'h0, 32'h0,        8'hFF, 1, 32'hA5A5A5A5});
    vecs.push_back('{1, 1, 8'hFF, 4'h0, 32'h00000000, 8'hFF, 1, 32'hA5A5A5A5});
    vecs.push_back('{1, 0, 8'h00, 4'h0, 32'h0,        8'hFF, 1, 32'hA5A5A5A5});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].we, vecs[i].wa, vecs[i].be, vecs[i].d, vecs[i].ra, exp);
      if (vecs[i].chk) check($sformatf("vec%0d", i), q, vecs[i].exp_q);
    end

    // Reset pulse between edges, with a write held across a reset-time edge
    step(1, 1, 8'h05, 4'hF, 32'h0ABC0DEF, 8'h06, exp);
    step(1, 0, 8'h00, 4'h0, 32'h0, 8'h05, exp);
    check("pre_reset_q", q, 32'h0ABC0DEF);
    enable = 1'b1; wren = 1'b1; wraddress = 8'h05; byteena_a = 4'hF; data = 32'h0; rdaddress = 8'h05;
    #1 reset_n = 1'b0;
    #1 check("reset_async_q", q, 32'h0);
    @(posedge clock);
    @(negedge clock);
    check("reset_hold_q", q, 32'h0);
    model_q = '0;
    reset_n = 1'b1;
    step(1, 0, 8'h00, 4'h0, 32'h0, 8'h05, exp);
    check("post_reset_read", q, 32'h0ABC0DEF);

    // Random traffic, small address window to provoke same-address collisions
    for (int i = 0; i < 400; i++) begin
      logic [7:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? wa : 8'($urandom_range(0, 7));
      step($urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, wa, 4'($urandom),
           $urandom, ra, exp);
      check("random", q, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit exceeded");
    $fatal(1, "timeout");
  end

endmodule : tb_denise_colortable_ram_mf

// File: doc/denise_colortable_ram_mf.md
DENISE_COLORTABLE_RAM_MF -- requirements
Module: denise_colortable_ram_mf

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning address width (depth = 2**ADDR_W words).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning word width; it must be a multiple of 8.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: global clock enable for both ports.
REQ-006 The block SHALL have port wraddress, input, ADDR_W bits: write address.
REQ-007 The block SHALL have port wren, input, 1 bit: write request.
REQ-008 The block SHALL have port byteena_a, input, DATA_W/8 bits: per-byte write enable, bit i covering data[8i+7:8i].
REQ-009 The block SHALL have port data, input, DATA_W bits: write data.
REQ-010 The block SHALL have port rdaddress, input, ADDR_W bits: read address.
REQ-011 The block SHALL have port q, output, DATA_W bits: registered read data.

Function
REQ-012 The block SHALL be a simple dual-port RAM: one write port and one read port, with independent addresses on the same clock.
REQ-013 On a rising edge with enable=1 and wren=1, each byte lane i with byteena_a[i]=1 SHALL be written from data; lanes with byteena_a[i]=0 SHALL keep their old value.
REQ-014 wren=1 with byteena_a all zero SHALL leave the memory unchanged.
REQ-015 On a rising edge with enable=1, q SHALL load mem[rdaddress]; read latency is exactly 1 cycle from the address to q.
REQ-016 With enable=0, no write SHALL occur and q SHALL hold its value, regardless of wren.
REQ-017 Same-address read and write in one enabled cycle SHALL follow REQ-024/REQ-025.
REQ-018 Addresses SHALL use the full ADDR_W range with no wrap logic; address 2**ADDR_W-1 is valid.
REQ-019 No handshake exists; every enabled cycle SHALL accept one write and one read.

Reset
REQ-020 reset_n=0 SHALL asynchronously clear q to all zeros.
REQ-021 Reset SHALL NOT clear memory contents; contents after power-up are undefined and remain unchanged across reset.
REQ-022 While reset_n=0, writes SHALL be blocked; operation resumes on the first rising edge after reset_n deasserts.
REQ-023 Reset asserted mid-write SHALL leave the target word either fully old or fully new per byte lane, never corrupting other addresses.

Configuration
REQ-024 With macro DENISE_CLUT_RDW_BYPASS_EN defined, a same-address read during a write SHALL return the new data: written lanes from data, unwritten lanes from the old word.
REQ-025 Without DENISE_CLUT_RDW_BYPASS_EN, a same-address read during a write SHALL return the old word (read-before-write).

Structure
REQ-026 The shared package denise_clut_pkg SHALL hold the ADDR_W/DATA_W defaults, the byte-lane count constant, and a byte-enable typedef.
REQ-027 The design SHALL use one sub-module, denise_clut_bytelane, instantiated DATA_W/8 times, each an 8-bit-wide, 2**ADDR_W-deep RAM slice with its own write enable.
REQ-028 The bypass merge and the q register SHALL live in the top level.

Verification
REQ-029 Full write then read: write 0x0ABC_0DEF to address 0x05 with byteena 4'b1111, then read address 0x05 -> q=0x0ABC0DEF one cycle after the read address.
REQ-030 Partial write: with address 0x05 holding 0x0ABC0DEF, write 0x0123_0456 with byteena 4'b0011, then read -> q=0x0ABC0456.
REQ-031 Enable gating: enable=0 while writing 0xFFFFFFFF to address 0x10, then read with enable=1 -> q equals the prior content; q held constant during the enable=0 cycles.
REQ-032 Read-during-write: with address 0x20 holding 0x11111111, write 0x22222222 with byteena 4'b1111 while reading address 0x20 -> q=0x22222222 with the bypass macro defined, q=0x11111111 without it.
REQ-033 Reset: with q=0x0ABC0DEF, pulse reset_n low between clock edges -> q=0 immediately; a later read of address 0x05 returns 0x0ABC0DEF.
REQ-034 Boundary: write 0xA5A5A5A5 to address 0xFF and 0x5A5A5A5A to address 0x00 -> both read back intact and independent.
